// File: rtl/psk_sweep_ctl.sv
// PSK acquisition sweep scheduler: per offset bin clears the correlators, strobes a fixed dwell,
// collects one metric and tracks the best bin. Define PSK_SWEEP_EARLY_LOCK_EN for early lock.
module psk_sweep_ctl #(
  parameter int unsigned OFFSET_W    = 4,
  parameter int unsigned NUM_OFFSETS = 16,
  parameter int unsigned STB_PERIOD  = 16,
  parameter int unsigned DUMPS       = 256,
  parameter int unsigned METRIC_W    = 8,
  parameter int unsigned TIMEOUT     = 1024
`ifdef PSK_SWEEP_EARLY_LOCK_EN
  ,
  parameter logic [METRIC_W-1:0] LOCK_THRESH = METRIC_W'(8'hC0)
`endif
) (
  input  logic                clk,
  input  logic                rst_in_n,
  input  logic                start,
  input  logic                abort,
  input  logic [METRIC_W-1:0] metric,
  input  logic                metric_vld,
  output logic [OFFSET_W-1:0] offset,
  output logic                corr_rst,
  output logic                stb,
  output logic                metric_req,
  output logic [OFFSET_W-1:0] best_offset,
  output logic [METRIC_W-1:0] best_metric,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CLR_W  = $clog2(2) + 1;
  localparam int unsigned STB_W  = $clog2(STB_PERIOD) + 1;
  localparam int unsigned DUMP_W = $clog2(DUMPS) + 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, DWELL, WAIT_M, COMPARE, FINISH} state_t;

  state_t              state, state_d;
  logic [OFFSET_W-1:0] offset_d, best_offset_d;
  logic [METRIC_W-1:0] best_metric_d, metric_q, metric_q_d;
  logic                busy_d, done_d, err_d, corr_rst_d, stb_d, metric_req_d;
  logic [CLR_W-1:0]    clr_cnt, clr_cnt_d;
  logic [STB_W-1:0]    stb_cnt, stb_cnt_d;
  logic [DUMP_W-1:0]   dump_cnt, dump_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state       <= IDLE;
      offset      <= '0;
      best_offset <= '0;
      best_metric <= '0;
      metric_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      corr_rst    <= 1'b0;
      stb         <= 1'b0;
      metric_req  <= 1'b0;
      clr_cnt     <= '0;
      stb_cnt     <= '0;
      dump_cnt    <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_d;
      offset      <= offset_d;
      best_offset <= best_offset_d;
      best_metric <= best_metric_d;
      metric_q    <= metric_q_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      corr_rst    <= corr_rst_d;
      stb         <= stb_d;
      metric_req  <= metric_req_d;
      clr_cnt     <= clr_cnt_d;
      stb_cnt     <= stb_cnt_d;
      dump_cnt    <= dump_cnt_d;
      wait_cnt    <= wait_cnt_d;
    end
  end

  // Next state, datapath updates and next output values
  always_comb begin
    state_d       = state;
    offset_d      = offset;
    best_offset_d = best_offset;
    best_metric_d = best_metric;
    metric_q_d    = metric_q;
    busy_d        = busy;
    err_d         = err;
    clr_cnt_d     = '0;
    stb_cnt_d     = '0;
    dump_cnt_d    = '0;
    wait_cnt_d    = '0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d       = CLEAR;
          offset_d      = '0;
          best_offset_d = '0;
          best_metric_d = '0;
          err_d         = 1'b0;
          busy_d        = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_W'(1)) state_d = DWELL;
        else                      clr_cnt_d = clr_cnt + CLR_W'(1);
      end
      DWELL: begin
        stb_cnt_d  = stb_cnt + STB_W'(1);
        dump_cnt_d = dump_cnt;
        if (stb_cnt == STB_W'(STB_PERIOD - 1)) begin
          stb_cnt_d  = '0;
          dump_cnt_d = dump_cnt + DUMP_W'(1);
          if (dump_cnt == DUMP_W'(DUMPS - 1)) begin
            dump_cnt_d = '0;
            state_d    = WAIT_M;
          end
        end
      end
      WAIT_M: begin
        if (metric_vld) begin
          metric_q_d = metric;
          state_d    = COMPARE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          metric_q_d = '0;
          err_d      = 1'b1;
          state_d    = COMPARE;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      COMPARE: begin
`ifdef PSK_SWEEP_EARLY_LOCK_EN
        if (metric_q >= LOCK_THRESH) begin
          best_metric_d = metric_q;
          best_offset_d = offset;
          state_d       = FINISH;
        end else
`endif
        begin
          // Strict compare so a tie keeps the earlier (lower) bin
          if (metric_q > best_metric) begin
            best_metric_d = metric_q;
            best_offset_d = offset;
          end
          if (offset == OFFSET_W'(NUM_OFFSETS - 1)) begin
            state_d = FINISH;
          end else begin
            offset_d = offset + OFFSET_W'(1);
            state_d  = CLEAR;
          end
        end
      end
      FINISH: begin
        offset_d = best_offset;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort parks the NCO on the best bin so far; partial results are kept
    if (abort && state != IDLE) begin
      state_d       = IDLE;
      offset_d      = best_offset;
      best_offset_d = best_offset;
      best_metric_d = best_metric;
      busy_d        = 1'b0;
      stb_cnt_d     = '0;
      dump_cnt_d    = '0;
      wait_cnt_d    = '0;
      clr_cnt_d     = '0;
    end

    corr_rst_d   = (state_d == CLEAR);
    stb_d        = (state_d == DWELL) && (stb_cnt_d == STB_W'(STB_PERIOD - 1));
    metric_req_d = stb_d && (dump_cnt_d == DUMP_W'(DUMPS - 1));
    done_d       = (state_d == FINISH);
  end

endmodule

// File: tb/tb_psk_sweep_ctl.sv
// Scoreboard bench for psk_sweep_ctl: stimulus queues expected metric requests and sweep results,
// a negedge monitor pops and compares them whenever the DUT presents metric_req or done.
module tb_psk_sweep_ctl;
  localparam int unsigned OFFSET_W    = 4;
  localparam int unsigned NUM_OFFSETS = 4;
  localparam int unsigned STB_PERIOD  = 4;
  localparam int unsigned DUMPS       = 2;
  localparam int unsigned METRIC_W    = 8;
  localparam int unsigned TIMEOUT     = 8;

  logic                clk = 1'b0;
  logic                rst_in_n, start, abort, metric_vld;
  logic [METRIC_W-1:0] metric;
  logic [OFFSET_W-1:0] offset, best_offset;
  logic [METRIC_W-1:0] best_metric;
  logic                corr_rst, stb, metric_req, busy, done, err;

  psk_sweep_ctl #(
    .OFFSET_W(OFFSET_W), .NUM_OFFSETS(NUM_OFFSETS), .STB_PERIOD(STB_PERIOD),
    .DUMPS(DUMPS), .METRIC_W(METRIC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_in_n(rst_in_n), .start(start), .abort(abort),
    .metric(metric), .metric_vld(metric_vld), .offset(offset), .corr_rst(corr_rst),
    .stb(stb), .metric_req(metric_req), .best_offset(best_offset),
    .best_metric(best_metric), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int best_off;
    int best_met;
    int err;
    int lat;
  } done_exp_t;

  done_exp_t done_q[$];
  int        req_q[$];
  int        rsp_q[$];
  int        n_vec = 0;
  int        n_bad = 0;
  int        cyc = 0;
  int        t0 = 0;
  bit        spur_en = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial forever @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: tracks clear/strobe shape per bin and checks each DUT event against the queues
  initial begin
    int clr_n, stb_n, since_stb, last_gap, e;
    bit corr_prev;
    done_exp_t d;
    clr_n = 0; stb_n = 0; since_stb = 0; last_gap = 0; corr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (corr_rst && !corr_prev) begin
        clr_n = 0; stb_n = 0; last_gap = 0;
      end
      if (corr_rst) clr_n++;
      corr_prev = corr_rst;
      since_stb++;
      if (stb) begin
        stb_n++;
        if (stb_n > 1) last_gap = since_stb;
        since_stb = 0;
      end
      if (metric_req) begin
        if (req_q.size() == 0) check("req_unexpected", 1, 0);
        else begin
          e = req_q.pop_front();
          check("req_offset", int'(offset), e);
          check("req_stb_count", stb_n, 2);
          check("req_clr_cycles", clr_n, 2);
          check("req_stb_gap", last_gap, 4);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          d = done_q.pop_front();
          check("done_best_offset", int'(best_offset), d.best_off);
          check("done_best_metric", int'(best_metric), d.best_met);
          check("done_err", int'(err), d.err);
          check("done_latency", cyc - t0, d.lat);
        end
      end
    end
  end

  // Datapath model: answers each metric_req one cycle later; -1 means no answer
  initial begin
    int m;
    metric_vld = 1'b0;
    metric     = '0;
    forever begin
      @(negedge clk);
      if (metric_req) begin
        m = (rsp_q.size() > 0) ? rsp_q.pop_front() : -1;
        @(negedge clk);
        if (m >= 0) begin
          metric     = METRIC_W'(m);
          metric_vld = 1'b1;
          @(negedge clk);
          metric_vld = 1'b0;
        end
      end else if (spur_en && stb && offset == OFFSET_W'(2)) begin
        spur_en    = 1'b0;
        metric     = METRIC_W'(200);
        metric_vld = 1'b1;
        @(negedge clk);
        metric_vld = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_stb_at(int bin);
    int n = 0;
    while (!(stb && offset == OFFSET_W'(bin)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stb_in_bin", int'(stb && offset == OFFSET_W'(bin)), 1);
  endtask

  function automatic int all_outs();
    return int'({offset, corr_rst, stb, metric_req, best_offset, best_metric, busy, done, err});
  endfunction

  initial begin
    int seen;
    rst_in_n = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst_in_n = 1'b1;
    @(negedge clk);

    // Reset asserted in DWELL on a strobe cycle
    pulse_start();
    repeat (5) @(negedge clk);
    check("pre_reset_stb", int'(stb), 1);
    #2 rst_in_n = 1'b0;
    #1 check("midsweep_reset_outputs", all_outs(), 0);
    @(negedge clk);
    rst_in_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", int'({busy, corr_rst, stb}), 0);

    // Full sweep, with an ignored start and an ignored metric_vld mid-sweep
    req_q = {0, 1, 2, 3};
    rsp_q = {10, 50, 30, 50};
    done_q.push_back('{1, 50, 0, 48});
    spur_en = 1'b1;
    pulse_start();
    wait_stb_at(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(200);
    check("s1_offset_after", int'(offset), 1);

    // Bin 2 never answers: timeout scores it 0 and sets err
    req_q = {0, 1, 2, 3};
    rsp_q = {10, 20, -1, 15};
    done_q.push_back('{1, 20, 1, 55});
    pulse_start();
    wait_idle(200);
    check("s2_err_sticky", int'(err), 1);

    // Abort in bin 2 after bins 0/1 scored 5/9
    req_q = {0, 1};
    rsp_q = {5, 9};
    pulse_start();
    check("s3_err_cleared", int'(err), 0);
    check("s3_offset_start", int'(offset), 0);
    wait_stb_at(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_offset", int'(offset), 1);
    check("abort_best_offset", int'(best_offset), 1);
    check("abort_best_metric", int'(best_metric), 9);
    check("abort_stb_clr", int'({corr_rst, stb}), 0);
    repeat (3) @(negedge clk);

    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    check("start_abort_idle", int'({busy, corr_rst}), 0);

    // Restart after abort: ties and full-scale metric
    req_q = {0, 1, 2, 3};
    rsp_q = {7, 7, 3, 255};
    done_q.push_back('{3, 255, 0, 48});
    pulse_start();
    check("s4_busy", int'(busy), 1);
    wait_idle(200);
    check("s4_offset_after", int'(offset), 3);

`ifdef PSK_SWEEP_EARLY_LOCK_EN
    req_q = {0, 1};
    rsp_q = {10, 197};
    done_q.push_back('{1, 197, 0, 24});
    pulse_start();
    wait_idle(200);
    check("lock_offset_after", int'(offset), 1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (corr_rst) seen = 1;
    end
    check("lock_no_more_clear", seen, 0);
`else
    seen = 0;
`endif

    repeat (4) @(negedge clk);
    check("req_q_drained", req_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("rsp_q_drained", rsp_q.size() + seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
